// File: rtl/lane_seg_mul_pkg.sv
// Shared definitions for the shared-multiplier arbiter.
//   - operand/product widths (16s x 10u -> 26s)
//   - mul_op_t: one captured multiply operation (requester id + operands)
//   - rr_pick: round-robin one-hot picker over an eligibility vector
//   - mul_ab: exact signed x unsigned product at full product width
package lane_seg_mul_pkg;

  localparam int A_W     = 16;
  localparam int B_W     = 10;
  localparam int P_W     = A_W + B_W;
  // Upper bound on requester count; rr_pick and id fields are sized for it.
  localparam int MAX_REQ = 32;
  localparam int ID_W    = $clog2(MAX_REQ);

  typedef struct packed {
    logic [ID_W-1:0]       id;
    logic signed [A_W-1:0] a;
    logic [B_W-1:0]        b;
  } mul_op_t;

  // First set bit of eligible at or after ptr, wrapping modulo n.
  // Returns all zeros when nothing is eligible.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] eligible,
    input int unsigned        ptr,
    input int unsigned        n
  );
    logic [MAX_REQ-1:0] grant;
    logic               found;
    int unsigned        idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = (ptr + k) % n;
        if (!found && eligible[idx[ID_W-1:0]]) begin
          grant[idx[ID_W-1:0]] = 1'b1;
          found                = 1'b1;
        end
      end
    end
    return grant;
  endfunction

  // Both operands are widened to the product width before multiplying, so
  // the truncated result is the exact product (it always fits in P_W bits).
  function automatic logic signed [P_W-1:0] mul_ab(
    input logic signed [A_W-1:0] a,
    input logic [B_W-1:0]        b
  );
    logic signed [P_W-1:0] ax;
    logic signed [P_W-1:0] bx;
    ax = {{B_W{a[A_W-1]}}, a};
    bx = {{A_W{1'b0}}, b};
    return ax * bx;
  endfunction

endpackage

// File: rtl/lane_seg_mul_share_arb_if.sv
// Request/response bundle between N_REQ requesters and the shared multiplier.
//   req_valid/req_ready : per-requester operation handshake (req_ready one-hot)
//   req_a/req_b         : packed operands, slice i belongs to requester i
//   rsp_valid/rsp_ready : per-requester result handshake
//   rsp_data            : packed products, slice i belongs to requester i
// master = requester side, slave = arbiter side.
interface lane_seg_mul_share_arb_if #(
  parameter int N_REQ = 4
) ();
  logic [N_REQ-1:0]                         req_valid;
  logic [N_REQ-1:0]                         req_ready;
  logic [N_REQ*lane_seg_mul_pkg::A_W-1:0]   req_a;
  logic [N_REQ*lane_seg_mul_pkg::B_W-1:0]   req_b;
  logic [N_REQ-1:0]                         rsp_valid;
  logic [N_REQ-1:0]                         rsp_ready;
  logic [N_REQ*lane_seg_mul_pkg::P_W-1:0]   rsp_data;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/lane_seg_mul_pipe.sv
// Pipelined signed x unsigned multiply feeding the result slots.
// The stage-1 register captures the granted operands; PIPE_STAGES-2 further
// registers carry the product. The result slot in the parent is the final
// register, so grant-to-rsp_valid latency is PIPE_STAGES cycles.
// With PIPE_STAGES == 1 the product is formed combinationally from the
// grant and the slot captures it on the grant edge.
// Ports:
//   ap_clk, ap_rst        clock, synchronous active-high reset (clears valids)
//   in_valid/in_a/in_b/in_id    granted operation
//   out_valid/out_p/out_id      product ready to be written into slot out_id
module lane_seg_mul_pipe
  import lane_seg_mul_pkg::*;
#(
  parameter int PIPE_STAGES = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  input  logic signed [A_W-1:0] in_a,
  input  logic [B_W-1:0]        in_b,
  input  logic [ID_W-1:0]       in_id,
  output logic                  out_valid,
  output logic signed [P_W-1:0] out_p,
  output logic [ID_W-1:0]       out_id
);

  localparam int DEPTH = PIPE_STAGES - 1;

  generate
    if (DEPTH == 0) begin : g_bypass
      assign out_valid = in_valid;
      assign out_p     = mul_ab(in_a, in_b);
      assign out_id    = in_id;
    end else begin : g_piped
      mul_op_t               op_reg;
      logic                  op_valid_reg;
      logic signed [P_W-1:0] prod_s1;

      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          op_valid_reg <= 1'b0;
        end else begin
          op_valid_reg <= in_valid;
        end
        if (in_valid) begin
          op_reg <= '{id: in_id, a: in_a, b: in_b};
        end
      end

      assign prod_s1 = mul_ab(op_reg.a, op_reg.b);

      if (DEPTH == 1) begin : g_last
        assign out_valid = op_valid_reg;
        assign out_p     = prod_s1;
        assign out_id    = op_reg.id;
      end else begin : g_tail
        logic signed [P_W-1:0] p_reg  [DEPTH-1];
        logic [ID_W-1:0]       id_reg [DEPTH-1];
        logic                  v_reg  [DEPTH-1];

        for (genvar gi = 0; gi < DEPTH - 1; gi++) begin : g_stage
          logic                  v_in;
          logic signed [P_W-1:0] p_in;
          logic [ID_W-1:0]       id_in;

          if (gi == 0) begin : g_src_s1
            assign v_in  = op_valid_reg;
            assign p_in  = prod_s1;
            assign id_in = op_reg.id;
          end else begin : g_src_prev
            assign v_in  = v_reg[gi-1];
            assign p_in  = p_reg[gi-1];
            assign id_in = id_reg[gi-1];
          end

          always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
              v_reg[gi] <= 1'b0;
            end else begin
              v_reg[gi] <= v_in;
            end
            p_reg[gi]  <= p_in;
            id_reg[gi] <= id_in;
          end
        end

        assign out_valid = v_reg[DEPTH-2];
        assign out_p     = p_reg[DEPTH-2];
        assign out_id    = id_reg[DEPTH-2];
      end
    end
  endgenerate

endmodule

// File: rtl/lane_seg_mul_share_arb.sv
// Shares one 16s x 10u multiplier between N_REQ requesters.
// A round-robin arbiter grants at most one eligible requester per cycle,
// the operation travels down lane_seg_mul_pipe, and the product lands in
// the issuing requester's result slot where it waits for rsp_ready.
// Ports:
//   ap_clk  clock
//   ap_rst  synchronous active-high reset; discards in-flight products
//   bus     slave side of lane_seg_mul_share_arb_if (req/rsp handshakes)
//   busy    any requester has an operation in flight or unacknowledged
module lane_seg_mul_share_arb
  import lane_seg_mul_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int PIPE_STAGES = 2
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  lane_seg_mul_share_arb_if.slave  bus,
  output logic                     busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]      pending_reg;
  logic [PTR_W-1:0]      rr_ptr_reg;
  logic [N_REQ-1:0]      eligible;
  logic [N_REQ-1:0]      grant;
  logic [MAX_REQ-1:0]    elig_ext;
  logic [MAX_REQ-1:0]    pick;
  logic                  unused_pick;
  logic                  gnt_any;
  logic [PTR_W-1:0]      gnt_idx;
  logic [PTR_W-1:0]      ptr_next;
  logic signed [A_W-1:0] gnt_a;
  logic [B_W-1:0]        gnt_b;
  logic [N_REQ-1:0]      rsp_valid_vec;
  logic [N_REQ-1:0]      rsp_hs;
  logic                  pipe_valid;
  logic signed [P_W-1:0] pipe_p;
  logic [ID_W-1:0]       pipe_id;

  // Registered pending keeps a requester out of arbitration during the cycle
  // of its own rsp handshake; it becomes eligible again the cycle after.
  assign eligible = bus.req_valid & ~pending_reg;

  always_comb begin
    elig_ext                = '0;
    elig_ext[N_REQ-1:0]     = eligible;
    pick                    = rr_pick(elig_ext, 32'(rr_ptr_reg), 32'(N_REQ));
    grant                   = ap_rst ? '0 : pick[N_REQ-1:0];
  end

  assign unused_pick = ^pick;
  assign gnt_any     = |grant;

  // One-hot grant to index and operand mux.
  always_comb begin
    gnt_idx = '0;
    gnt_a   = '0;
    gnt_b   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gnt_idx = PTR_W'(i);
        gnt_a   = bus.req_a[i*A_W +: A_W];
        gnt_b   = bus.req_b[i*B_W +: B_W];
      end
    end
  end

  assign ptr_next = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign rsp_hs   = rsp_valid_vec & bus.rsp_ready;

  // A bit cannot be set and cleared in the same cycle: a grant needs the
  // bit clear, an rsp handshake needs a held result, which implies it set.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rr_ptr_reg  <= '0;
      pending_reg <= '0;
    end else begin
      if (gnt_any) begin
        rr_ptr_reg <= ptr_next;
      end
      pending_reg <= (pending_reg | grant) & ~rsp_hs;
    end
  end

  lane_seg_mul_pipe #(
    .PIPE_STAGES (PIPE_STAGES)
  ) u_pipe (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_valid  (gnt_any),
    .in_a      (gnt_a),
    .in_b      (gnt_b),
    .in_id     (ID_W'(gnt_idx)),
    .out_valid (pipe_valid),
    .out_p     (pipe_p),
    .out_id    (pipe_id)
  );

  // Per-requester result slots. The pending rule guarantees an arriving
  // product never targets a slot that is still occupied or being consumed.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
      logic            slot_valid_reg;
      logic [P_W-1:0]  slot_data_reg;

      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          slot_valid_reg <= 1'b0;
          slot_data_reg  <= '0;
        end else if (pipe_valid && (pipe_id == ID_W'(gi))) begin
          slot_valid_reg <= 1'b1;
          slot_data_reg  <= pipe_p;
        end else if (rsp_hs[gi]) begin
          slot_valid_reg <= 1'b0;
        end
      end

      assign rsp_valid_vec[gi]             = slot_valid_reg;
      assign bus.rsp_data[gi*P_W +: P_W]   = slot_data_reg;
    end
  endgenerate

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_vec;
  assign busy          = |pending_reg;

endmodule

// File: tb/tb_lane_seg_mul_share_arb.sv
// Self-checking bench for lane_seg_mul_share_arb (N_REQ=4, PIPE_STAGES=2).
// A transaction-level model (pending flags, round-robin pointer, a queue of
// in-flight products tagged with their due cycle, per-requester result slots)
// predicts every output each cycle; directed scenarios add fixed expectations.
module tb_lane_seg_mul_share_arb;
  import lane_seg_mul_pkg::*;

  localparam int N    = 4;
  localparam int PIPE = 2;

  logic ap_clk = 1'b0;
  logic ap_rst;
  logic busy;

  lane_seg_mul_share_arb_if #(.N_REQ(N)) bus ();

  lane_seg_mul_share_arb #(
    .N_REQ       (N),
    .PIPE_STAGES (PIPE)
  ) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus),
    .busy   (busy)
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;
  bit verbose = 1'b1;

  // ---------------- reference model ----------------
  typedef struct {
    int             id;
    logic [P_W-1:0] prod;
    int             due;
  } flight_t;

  int             cyc;
  int             m_ptr;
  bit [N-1:0]     m_pend;
  bit [N-1:0]     m_rv;
  logic [P_W-1:0] m_rd [N];
  flight_t        flight [$];
  int             n_issued;

  logic [N-1:0]     exp_ready;
  logic [N-1:0]     exp_rv;
  logic [N*P_W-1:0] exp_rd;
  logic             exp_busy;

  task automatic model_reset();
    m_ptr  = 0;
    m_pend = '0;
    m_rv   = '0;
    for (int i = 0; i < N; i++) m_rd[i] = '0;
    flight.delete();
  endtask

  // Expected outputs for the current cycle (inputs already driven).
  task automatic eval();
    int idx;
    #1;
    exp_ready = '0;
    if (!ap_rst) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (exp_ready == '0 && bus.req_valid[idx] && !m_pend[idx]) exp_ready[idx] = 1'b1;
      end
    end
    exp_rv = m_rv;
    for (int i = 0; i < N; i++) exp_rd[i*P_W +: P_W] = m_rd[i];
    exp_busy = |m_pend;
  endtask

  // Advance the model across the coming rising edge, then wait for the
  // falling edge where the next inputs are driven.
  task automatic tick();
    longint p;
    if (ap_rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_rv[i] && bus.rsp_ready[i]) begin
          m_rv[i]   = 1'b0;
          m_pend[i] = 1'b0;
          if (verbose) $display("txn retire id=%0d data=%h cyc=%0d", i, m_rd[i], cyc);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (exp_ready[i]) begin
          p = longint'($signed(bus.req_a[i*A_W +: A_W])) * longint'(bus.req_b[i*B_W +: B_W]);
          m_pend[i] = 1'b1;
          m_ptr     = (i + 1) % N;
          flight.push_back('{id: i, prod: p[P_W-1:0], due: cyc + PIPE});
          n_issued++;
          if (verbose) $display("txn grant  id=%0d a=%h b=%h cyc=%0d", i,
                                bus.req_a[i*A_W +: A_W], bus.req_b[i*B_W +: B_W], cyc);
        end
      end
      while (flight.size() > 0 && flight[0].due == cyc + 1) begin
        m_rv[flight[0].id] = 1'b1;
        m_rd[flight[0].id] = flight[0].prod;
        void'(flight.pop_front());
      end
    end
    cyc++;
    @(negedge ap_clk);
  endtask

  task automatic apply_reset();
    ap_rst = 1'b1;
    eval();
    tick();
    ap_rst = 1'b0;
  endtask

  task automatic rand_operands();
    int k;
    for (int i = 0; i < N; i++) begin
      k = $urandom_range(0, 7);
      bus.req_a[i*A_W +: A_W] = (k == 0) ? 16'h8000 : (k == 1) ? 16'h7fff : 16'($urandom);
      k = $urandom_range(0, 7);
      bus.req_b[i*B_W +: B_W] = (k == 0) ? 10'd0 : (k == 1) ? 10'd1023 : 10'($urandom);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    ap_rst = 1'b1;
    for (int t = 0; t < 3; t++) begin
      bus.req_valid = 4'($urandom);
      bus.rsp_ready = 4'($urandom);
      eval();
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, busy} !== {exp_ready, exp_rv, exp_rd, exp_busy}) begin
        errors++;
        $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc,
                 {bus.req_ready, bus.rsp_valid, bus.rsp_data, busy}, {exp_ready, exp_rv, exp_rd, exp_busy});
      end
      checks++;
      if (bus.req_ready !== 4'b0 || bus.rsp_valid !== 4'b0 || busy !== 1'b0 || bus.rsp_data !== '0) begin
        errors++;
        $display("FAIL reset_state cyc=%0d got ready=%b rv=%b busy=%b data=%h exp all zero", cyc,
                 bus.req_ready, bus.rsp_valid, busy, bus.rsp_data);
      end
      checks++;
      tick();
    end
    ap_rst        = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
  endtask

  task automatic test_single();
    apply_reset();
    bus.req_a[0 +: A_W] = 16'h8000;
    bus.req_b[0 +: B_W] = 10'd1023;
    bus.rsp_ready       = 4'b0001;
    for (int t = 0; t < 12; t++) begin
      bus.req_valid = (t == 5) ? 4'b0001 : 4'b0000;
      eval();
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, busy} !== {exp_ready, exp_rv, exp_rd, exp_busy}) begin
        errors++;
        $display("FAIL single_model t=%0d got=%h exp=%h", t,
                 {bus.req_ready, bus.rsp_valid, bus.rsp_data, busy}, {exp_ready, exp_rv, exp_rd, exp_busy});
      end
      checks++;
      if (t == 5) begin
        if (bus.req_ready !== 4'b0001) begin
          errors++;
          $display("FAIL single_grant got=%b exp=0001", bus.req_ready);
        end
        checks++;
      end
      if (t == 6) begin
        if (bus.rsp_valid !== 4'b0000) begin
          errors++;
          $display("FAIL single_early got=%b exp=0000", bus.rsp_valid);
        end
        checks++;
      end
      if (t == 7) begin
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_data[P_W-1:0] !== 26'h2008000) begin
          errors++;
          $display("FAIL single_result got rv=%b data=%h exp rv=0001 data=2008000",
                   bus.rsp_valid, bus.rsp_data[P_W-1:0]);
        end
        checks++;
      end
      tick();
    end
  endtask

  task automatic test_all_four();
    apply_reset();
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 4'b1111;
    for (int t = 0; t < 14; t++) begin
      rand_operands();
      if (t >= 10) bus.req_valid = 4'b0000;
      eval();
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, busy} !== {exp_ready, exp_rv, exp_rd, exp_busy}) begin
        errors++;
        $display("FAIL all_four_model t=%0d got=%h exp=%h", t,
                 {bus.req_ready, bus.rsp_valid, bus.rsp_data, busy}, {exp_ready, exp_rv, exp_rd, exp_busy});
      end
      checks++;
      if (t < 4) begin
        if (bus.req_ready !== 4'(1 << t)) begin
          errors++;
          $display("FAIL all_four_grant t=%0d got=%b exp=%b", t, bus.req_ready, 4'(1 << t));
        end
        checks++;
      end
      if (t >= 2 && t < 6) begin
        if (bus.rsp_valid !== 4'(1 << (t - 2))) begin
          errors++;
          $display("FAIL all_four_rsp t=%0d got=%b exp=%b", t, bus.rsp_valid, 4'(1 << (t - 2)));
        end
        checks++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int seq [7] = '{0, 1, 2, 3, 0, 2, 3};
    int grants1;
    grants1 = 0;
    apply_reset();
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 4'b1101;
    for (int t = 0; t < 20; t++) begin
      rand_operands();
      if (t == 14) begin
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 4'b1111;
      end
      eval();
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, busy} !== {exp_ready, exp_rv, exp_rd, exp_busy}) begin
        errors++;
        $display("FAIL backpressure_model t=%0d got=%h exp=%h", t,
                 {bus.req_ready, bus.rsp_valid, bus.rsp_data, busy}, {exp_ready, exp_rv, exp_rd, exp_busy});
      end
      checks++;
      if (t < 7) begin
        if (bus.req_ready !== 4'(1 << seq[t])) begin
          errors++;
          $display("FAIL backpressure_order t=%0d got=%b exp=%b", t, bus.req_ready, 4'(1 << seq[t]));
        end
        checks++;
      end
      if (t < 14 && bus.req_ready[1] === 1'b1) grants1++;
      tick();
    end
    if (grants1 !== 1) begin
      errors++;
      $display("FAIL backpressure_req1_grants got=%0d exp=1", grants1);
    end
    checks++;
  endtask

  task automatic test_regrant();
    int first_g;
    int second_g;
    first_g  = -1;
    second_g = -1;
    apply_reset();
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 4'b0010;
    for (int t = 0; t < 12; t++) begin
      rand_operands();
      if (t == 8) bus.req_valid = 4'b0000;
      eval();
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, busy} !== {exp_ready, exp_rv, exp_rd, exp_busy}) begin
        errors++;
        $display("FAIL regrant_model t=%0d got=%h exp=%h", t,
                 {bus.req_ready, bus.rsp_valid, bus.rsp_data, busy}, {exp_ready, exp_rv, exp_rd, exp_busy});
      end
      checks++;
      if (bus.req_ready[1] === 1'b1) begin
        if (first_g < 0) first_g = t;
        else if (second_g < 0) second_g = t;
      end
      tick();
    end
    if (first_g < 0 || second_g < 0 || (second_g - first_g) != PIPE + 1) begin
      errors++;
      $display("FAIL regrant_gap got first=%0d second=%0d exp gap=%0d", first_g, second_g, PIPE + 1);
    end
    checks++;
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    bus.rsp_ready = 4'b1111;
    for (int t = 0; t < 12; t++) begin
      rand_operands();
      ap_rst        = (t == 1);
      bus.req_valid = (t == 0) ? 4'b0010 : (t == 1) ? 4'b0011 : (t == 7) ? 4'b1010 : 4'b0000;
      eval();
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, busy} !== {exp_ready, exp_rv, exp_rd, exp_busy}) begin
        errors++;
        $display("FAIL midreset_model t=%0d got=%h exp=%h", t,
                 {bus.req_ready, bus.rsp_valid, bus.rsp_data, busy}, {exp_ready, exp_rv, exp_rd, exp_busy});
      end
      checks++;
      if (t >= 1 && t < 7) begin
        if (bus.rsp_valid !== 4'b0000) begin
          errors++;
          $display("FAIL midreset_discard t=%0d got=%b exp=0000", t, bus.rsp_valid);
        end
        checks++;
      end
      if (t == 7) begin
        if (bus.req_ready !== 4'b0010) begin
          errors++;
          $display("FAIL midreset_ptr got=%b exp=0010", bus.req_ready);
        end
        checks++;
      end
      tick();
    end
    ap_rst = 1'b0;
  endtask

  task automatic test_random();
    int obs_retired;
    obs_retired = 0;
    apply_reset();
    n_issued = 0;
    verbose  = 1'b0;
    for (int t = 0; t < 10000; t++) begin
      rand_operands();
      bus.req_valid = 4'($urandom);
      bus.rsp_ready = 4'($urandom);
      if (t >= 9990) begin
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 4'b1111;
      end
      eval();
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, busy} !== {exp_ready, exp_rv, exp_rd, exp_busy}) begin
        errors++;
        $display("FAIL random_model t=%0d got=%h exp=%h", t,
                 {bus.req_ready, bus.rsp_valid, bus.rsp_data, busy}, {exp_ready, exp_rv, exp_rd, exp_busy});
      end
      checks++;
      obs_retired += $countones(bus.rsp_valid & bus.rsp_ready);
      tick();
    end
    verbose = 1'b1;
    if (obs_retired !== n_issued || busy !== 1'b0) begin
      errors++;
      $display("FAIL random_conservation got retired=%0d busy=%b exp retired=%0d busy=0",
               obs_retired, busy, n_issued);
    end
    checks++;
    $display("txn random summary issued=%0d retired=%0d", n_issued, obs_retired);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '0;
    ap_rst        = 1'b1;
    cyc           = 0;
    n_issued      = 0;
    model_reset();
    @(negedge ap_clk);
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_regrant();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
